twi_sniffer: RTL

TWI_SNIFFER -- requirements
Module: twi_sniffer

---
 rtl/twi_sniffer.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/twi_sniffer.sv
// twi_sniffer -- passive observer for a two-wire (I2C-style) bus.
//
// Watches raw SCL/SDA, recognises START, repeated START, STOP and complete
// bytes (8 data bits + ACK bit), and queues each as an event in a small
// first-word-fall-through FIFO for a downstream consumer.
//
// Parameters:
//   FIFO_DEPTH  event FIFO entries (power of two, >= 2)
//   FILTER_LEN  consecutive equal samples needed to accept a line change
//               (only used when TWI_SNIFFER_GLITCH_FILTER_EN is defined)
//
// Optional feature macro:
//   TWI_SNIFFER_GLITCH_FILTER_EN  adds a per-line sample-count glitch filter
//                                 between the synchronizers and edge detection.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   hostScl, hostSdaIn    raw asynchronous bus lines
//   evtValid / evtReady   event handshake: an entry is consumed on a clock
//                         edge where both are high. While evtValid is high
//                         and evtReady low, evtType/evtData/evtAck hold.
//   evtType               0 START, 1 RESTART, 2 STOP, 3 BYTE
//   evtData, evtAck       byte value (MSB first) and ACK flag; 0 otherwise
//   busy                  transaction open (state not IDLE)
//   overflow              sticky, an event was dropped on a full FIFO
//   dbgState              current FSM state (0 IDLE, 1 BITS, 2 ACK)
module twi_sniffer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hostScl,
    input  logic       hostSdaIn,
    output logic       evtValid,
    input  logic       evtReady,
    output logic [1:0] evtType,
    output logic [7:0] evtData,
    output logic       evtAck,
    output logic       busy,
    output logic       overflow,
    output logic [1:0] dbgState
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] EVT_START   = 2'd0;
    localparam logic [1:0] EVT_RESTART = 2'd1;
    localparam logic [1:0] EVT_STOP    = 2'd2;
    localparam logic [1:0] EVT_BYTE    = 2'd3;

    // Elaboration-time parameter sanity checks.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("twi_sniffer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (FILTER_LEN < 1) begin : gBadFilter
        $error("twi_sniffer: FILTER_LEN must be >= 1");
    end

    // ------------------------------------------------------------------
    // Line conditioning: 2-flop synchronizers, optional filter, previous
    // value registers. Everything resets to 1 (idle bus) so releasing
    // reset never fabricates an edge.
    // ------------------------------------------------------------------
    logic [1:0] sclSync;
    logic [1:0] sdaSync;
    logic       sclLine;
    logic       sdaLine;
    logic       sclPrev;
    logic       sdaPrev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
        end else begin
            sclSync <= {sclSync[0], hostScl};
            sdaSync <= {sdaSync[0], hostSdaIn};
        end
    end

`ifdef TWI_SNIFFER_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    syncLine;
    logic [1:0]    fltLine;
    logic [CW-1:0] fltCnt [2];

    assign syncLine = {sdaSync[1], sclSync[1]};

    // Counter counts consecutive samples that disagree with the accepted
    // value; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                fltLine[i] <= 1'b1;
                fltCnt[i]  <= '0;
            end else if (syncLine[i] == fltLine[i]) begin
                fltCnt[i]  <= '0;
            end else if (fltCnt[i] == CW'(FILTER_LEN - 1)) begin
                fltLine[i] <= syncLine[i];
                fltCnt[i]  <= '0;
            end else begin
                fltCnt[i]  <= fltCnt[i] + CW'(1);
            end
        end
    end

    assign sclLine = fltLine[0];
    assign sdaLine = fltLine[1];
`else
    assign sclLine = sclSync[1];
    assign sdaLine = sdaSync[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPrev <= sclLine;
            sdaPrev <= sdaLine;
        end
    end

    logic sclRise;
    logic sclHighStable;
    logic startCond;
    logic stopCond;

    assign sclRise       = sclLine & ~sclPrev;
    assign sclHighStable = sclLine & sclPrev;
    assign startCond     = sclHighStable & ~sdaLine &  sdaPrev;
    assign stopCond      = sclHighStable &  sdaLine & ~sdaPrev;

    // ------------------------------------------------------------------
    // Protocol FSM. Push request is registered, so the FIFO write lands
    // one cycle after the condition is seen.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACK  = 2'd2
    } stateType;

    stateType   state;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic       pushValid;
    logic [1:0] pushType;
    logic [7:0] pushData;
    logic       pushAck;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            pushValid <= 1'b0;
            pushType  <= '0;
            pushData  <= '0;
            pushAck   <= 1'b0;
        end else begin
            pushValid <= 1'b0;
            if (startCond) begin
                pushValid <= 1'b1;
                pushType  <= (state == IDLE) ? EVT_START : EVT_RESTART;
                pushData  <= '0;
                pushAck   <= 1'b0;
                state     <= BITS;
                bitCnt    <= '0;
                shiftReg  <= '0;
            end else if (stopCond) begin
                if (state != IDLE) begin
                    pushValid <= 1'b1;
                    pushType  <= EVT_STOP;
                    pushData  <= '0;
                    pushAck   <= 1'b0;
                    state     <= IDLE;
                    bitCnt    <= '0;
                    shiftReg  <= '0;
                end
            end else if (sclRise) begin
                case (state)
                    BITS: begin
                        shiftReg <= {shiftReg[6:0], sdaLine};
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            state <= ACK;
                        end
                    end
                    ACK: begin
                        pushValid <= 1'b1;
                        pushType  <= EVT_BYTE;
                        pushData  <= shiftReg;
                        pushAck   <= ~sdaLine;
                        state     <= BITS;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy     = (state != IDLE);
    assign dbgState = state;

    // ------------------------------------------------------------------
    // Event FIFO, first-word-fall-through. Pointers carry one extra bit
    // to tell full from empty.
    // ------------------------------------------------------------------
    logic [10:0] mem [FIFO_DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic        empty;
    logic        full;
    logic        doPush;
    logic        doPop;
    logic [10:0] head;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = evtValid & evtReady;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign doPush = pushValid & (~full | doPop);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= {pushType, pushData, pushAck};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + (AW + 1)'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + (AW + 1)'(1);
            end
            if (pushValid && !doPush) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head     = mem[rdPtr[AW-1:0]];
    assign evtValid = ~empty;
    assign evtType  = evtValid ? head[10:9] : 2'd0;
    assign evtData  = evtValid ? head[8:1]  : 8'd0;
    assign evtAck   = evtValid ? head[0]    : 1'b0;

endmodule
